// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word.
// Range-checks immediates and queues results in a 2-entry output FIFO.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready request handshake
//   fmt               0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   opcode, rd, rs1, rs2, funct3, funct7, imm   decoded fields
//   out_valid/out_ready  result handshake
//   instr, range_err  head entry (zero when out_valid=0)
//   word_count        error-free words popped (saturating)
//   err_count         erroneous words popped (saturating)
module instr_encoder #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         fmt,
  input  logic [6:0]         opcode,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [31:0]        imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        instr,
  output logic               range_err,
  output logic [COUNT_W-1:0] word_count,
  output logic [COUNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  typedef struct packed {
    logic        err;
    logic [31:0] word;
  } ent_t;

  logic        i_ok;
  logic        b_ok;
  logic        j_ok;
  logic        u_ok;
  logic [31:0] enc_word;
  logic        enc_bad;
  ent_t        new_ent;

  // Sign-extension checks: the upper bits must all match the sign bit.
  assign i_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_ok = ~imm[0] & ((&imm[31:12]) | ~(|imm[31:12]));
  assign j_ok = ~imm[0] & ((&imm[31:20]) | ~(|imm[31:20]));
  assign u_ok = ~(|imm[11:0]);

  always_comb begin
    enc_word = '0;
    enc_bad  = 1'b0;
    unique case (fmt)
      FMT_R: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_bad  = ~i_ok;
      end
      FMT_S: begin
        enc_word = {imm[11:5], rs2, rs1, funct3,
                    imm[4:0], opcode};
        enc_bad  = ~i_ok;
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                    imm[4:1], imm[11], opcode};
        enc_bad  = ~b_ok;
      end
      FMT_U: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_bad  = ~u_ok;
      end
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11],
                    imm[19:12], rd, opcode};
        enc_bad  = ~j_ok;
      end
      default: begin
        enc_bad  = 1'b1;
      end
    endcase
  end

  // Rejected requests still occupy a slot, with a zeroed word.
  assign new_ent.err  = enc_bad;
  assign new_ent.word = enc_bad ? 32'h0 : enc_word;

  ent_t       mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;
  ent_t       head;

  // Both handshakes derive from registered occupancy only.
  assign in_ready  = ~count[1];
  assign out_valid = |count;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem[rd_ptr];

  assign instr     = out_valid ? head.word : 32'h0;
  assign range_err = out_valid & head.err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_ent;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_count <= '0;
      err_count  <= '0;
    end else if (pop) begin
      if (!head.err && !(&word_count)) begin
        word_count <= word_count + COUNT_W'(1);
      end
      if (head.err && !(&err_count)) begin
        err_count <= err_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder.
// Expected words are queued on accept and compared on pop.
module tb_instr_encoder;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    fmt;
  logic [6:0]    opcode;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   instr;
  logic          range_err;
  logic [CW-1:0] word_count;
  logic [CW-1:0] err_count;

  instr_encoder #(.COUNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fmt        (fmt),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .funct7     (funct7),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr      (instr),
    .range_err  (range_err),
    .word_count (word_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [32:0] sb [$];
  int exp_w = 0;
  int exp_e = 0;
  int max_c = (1 << CW) - 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  // Reference encoder using signed range comparisons.
  function automatic logic [32:0] model(
    input logic [2:0] f, input logic [6:0] op,
    input logic [4:0] d, input logic [4:0] s1,
    input logic [4:0] s2, input logic [2:0] f3,
    input logic [6:0] f7, input logic [31:0] im);
    int si;
    logic ok;
    logic [31:0] w;
    si = int'(im);
    ok = 1'b1;
    w  = '0;
    case (f)
      3'd0: w = {f7, s2, s1, f3, d, op};
      3'd1: begin
        ok = si >= -2048 && si <= 2047;
        w  = {im[11:0], s1, f3, d, op};
      end
      3'd2: begin
        ok = si >= -2048 && si <= 2047;
        w  = {im[11:5], s2, s1, f3, im[4:0], op};
      end
      3'd3: begin
        ok = !im[0] && si >= -4096 && si <= 4095;
        w  = {im[12], im[10:5], s2, s1, f3,
              im[4:1], im[11], op};
      end
      3'd4: begin
        ok = (im % 4096) == 0;
        w  = {im[31:12], d, op};
      end
      3'd5: begin
        ok = !im[0] && si >= -1048576 && si <= 1048575;
        w  = {im[20], im[10:1], im[11], im[19:12], d, op};
      end
      default: ok = 1'b0;
    endcase
    return ok ? {1'b0, w} : {1'b1, 32'h0};
  endfunction

  task automatic send(input logic [2:0] f,
                      input logic [6:0] op,
                      input logic [4:0] d,
                      input logic [4:0] s1,
                      input logic [4:0] s2,
                      input logic [2:0] f3,
                      input logic [6:0] f7,
                      input logic [31:0] im,
                      input logic [32:0] e);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    fmt = f; opcode = op; rd = d; rs1 = s1;
    rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    else sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [2:0] f,
                        input logic [6:0] op,
                        input logic [4:0] d,
                        input logic [4:0] s1,
                        input logic [4:0] s2,
                        input logic [2:0] f3,
                        input logic [6:0] f7,
                        input logic [31:0] im);
    send(f, op, d, s1, s2, f3, f7, im,
         model(f, op, d, s1, s2, f3, f7, im));
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
      @(posedge clk);
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("instr", instr, e[31:0]);
        chk("range_err", range_err, e[32]);
        if (e[32]) begin
          if (exp_e < max_c) exp_e++;
        end else begin
          if (exp_w < max_c) exp_w++;
        end
      end
    end
  end

  initial begin
    logic [31:0] im;
    logic [2:0]  f;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0;
    rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_words", word_count, 0);
    chk("rst_errs", err_count, 0);

    // I-format with latency check
    out_ready = 1'b1;
    send(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0,
         32'hFFFF_FFFF, {1'b0, 32'hFFF10093});
    chk("latency_valid", out_valid, 1);
    chk("latency_instr", instr, 32'hFFF10093);
    drain();
    chk("words_after_i", word_count, 1);

    send(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0,
         32'd8, {1'b0, 32'h00512423});
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
         -32'sd4, {1'b0, 32'hFE000EE3});
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
         32'd2048, {1'b0, 32'h001000EF});
    send(3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0,
         32'h12345000, {1'b0, 32'h123451B7});
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20,
         32'h0, {1'b0, 32'h402081B3});
    drain();
    chk("words_after_fmts", word_count, 6);

    // Range errors
    send(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0,
         32'd2048, {1'b1, 32'h0});
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
         32'd3, {1'b1, 32'h0});
    send(3'd7, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0,
         32'd0, {1'b1, 32'h0});
    drain();
    chk("errs_after_err", err_count, 3);
    chk("words_after_err", word_count, 6);

    // Backpressure: third request held until space frees
    out_ready = 1'b0;
    send_m(3'd1, 7'h13, 5'd4, 5'd5, 5'd0, 3'd0, 7'd0, 32'd100);
    send_m(3'd1, 7'h13, 5'd6, 5'd7, 5'd0, 3'd1, 7'd0, 32'd200);
    chk("full_in_ready", in_ready, 0);
    fork
      send_m(3'd1, 7'h13, 5'd8, 5'd9, 5'd0, 3'd2, 7'd0, 32'd300);
      begin
        repeat (3) @(posedge clk);
        #1 chk("held_in_ready", in_ready, 0);
        chk("held_head", instr, 32'h06428213);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("words_after_bp", word_count, 9);

    // Occupancy 1 with simultaneous push and pop
    out_ready = 1'b0;
    send_m(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    out_ready = 1'b1;
    send_m(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 32'd0);
    chk("occ1_valid", out_valid, 1);
    chk("occ1_in_ready", in_ready, 1);
    chk("occ1_head", instr, 32'h00628233);
    drain();
    chk("words_after_occ1", word_count, 11);

    // Reset with two buffered words
    out_ready = 1'b0;
    send_m(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
    send_m(3'd1, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    exp_w = 0;
    exp_e = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_instr", instr, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_words", word_count, 0);
    chk("mid_rst_errs", err_count, 0);

    // Random mix, long enough to saturate the counters
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 3) != 0;
      f = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: im = $urandom;
        1: im = 32'(int'($urandom_range(0, 8191)) - 4096);
        2: im = $urandom & 32'hFFFF_F000;
        default: im = 32'(int'($urandom_range(0, 4095)) - 2048)
                      & 32'hFFFF_FFFE;
      endcase
      send_m(f, 7'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), 3'($urandom), 7'($urandom), im);
    end
    out_ready = 1'b1;
    drain();
    chk("final_words", word_count, exp_w);
    chk("final_errs", err_count, exp_e);
    chk("final_empty", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
